// File: rtl/cache_pkg.sv
// Shared types and geometry for the 2-way, 32-set, 16-byte-line tag controller.
package cache_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned OFS_W  = 4;
  localparam int unsigned IDX_W  = 5;
  localparam int unsigned TAG_W  = ADDR_W - IDX_W - OFS_W;

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    REFILL,
    WRITE
  } state_e;

  function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1 -: TAG_W];
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] addr);
    return addr[OFS_W +: IDX_W];
  endfunction

endpackage

// File: rtl/cache_lru_valid.sv
// Per-set valid bits (one per way) and LRU bit, with a combinational read port,
// a single update port and a whole-array valid clear for flush.
module cache_lru_valid #(
  parameter int unsigned IDX_W = 5
) (
  input  logic             i_clk,
  input  logic             i_resetb,
  input  logic [IDX_W-1:0] i_rd_idx,
  output logic [1:0]       o_rd_valid,
  output logic             o_rd_lru,
  input  logic [IDX_W-1:0] i_upd_idx,
  input  logic             i_lru_we,
  input  logic             i_lru_val,
  input  logic             i_vld_set,
  input  logic             i_vld_way,
  input  logic             i_flush_clr
);
  import cache_pkg::*;

  localparam int unsigned NumSets = 1 << IDX_W;

  logic [NumSets-1:0][1:0] r_valid;
  logic [NumSets-1:0]      r_lru;

  assign o_rd_valid = r_valid[i_rd_idx];
  assign o_rd_lru   = r_lru[i_rd_idx];

  // Valid/LRU state; flush clear wins over a concurrent valid set.
  always_ff @(posedge i_clk) begin
    if (!i_resetb) begin
      r_valid <= '0;
      r_lru   <= '0;
    end else begin
      if (i_lru_we) begin
        r_lru[i_upd_idx] <= i_lru_val;
      end
      if (i_flush_clr) begin
        r_valid <= '0;
      end else if (i_vld_set) begin
        r_valid[i_upd_idx][i_vld_way] <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/cache_tag_ctrl.sv
// Tag-array initiator for a 2-way, 32-set cache: lookup, victim select, refill
// handshake and tag write. Optional hit/miss counters under CACHE_TAG_STATS_EN.
module cache_tag_ctrl #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned OFS_W  = 4,
  parameter int unsigned IDX_W  = 5,
  parameter int unsigned TAG_W  = 23
) (
  input  logic              i_clk,
  input  logic              i_resetb,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic [ADDR_W-1:0] i_req_addr,
  output logic              o_rsp_valid,
  output logic              o_rsp_hit,
  output logic              o_rsp_way,
  output logic              o_refill_req,
  output logic [ADDR_W-1:0] o_refill_addr,
  output logic              o_refill_way,
  input  logic              i_refill_done,
  input  logic              i_flush,
  output logic              o_ta_cs,
  output logic              o_ta_oe,
  output logic [1:0]        o_ta_web,
  output logic [IDX_W-1:0]  o_ta_a,
  output logic [TAG_W-1:0]  o_ta_di,
  input  logic [TAG_W-1:0]  i_ta_do0,
  input  logic [TAG_W-1:0]  i_ta_do1
`ifdef CACHE_TAG_STATS_EN
  ,
  output logic [31:0]       o_hit_cnt,
  output logic [31:0]       o_miss_cnt
`endif
);
  import cache_pkg::*;

  state_e                  r_state, w_state_d;
  logic [ADDR_W-1:OFS_W]   r_line;
  logic                    r_victim;
  logic                    r_flush_pend;
  logic                    r_rsp_valid, r_rsp_hit, r_rsp_way;
  logic                    r_refill_req;

  logic [TAG_W-1:0]        w_tag;
  logic [IDX_W-1:0]        w_idx;
  logic [1:0]              w_valid;
  logic                    w_lru;
  logic                    w_hit0, w_hit1, w_hit, w_hit_way, w_victim;
  logic                    w_accept, w_flush_clr;
  logic                    w_lru_we, w_lru_val;
  logic                    w_unused_ofs;

  // Offset bits never reach the tag array.
  assign w_unused_ofs = ^i_req_addr[OFS_W-1:0];

  assign w_tag = r_line[ADDR_W-1 -: TAG_W];
  assign w_idx = r_line[OFS_W +: IDX_W];

  assign w_hit0    = w_valid[0] && (i_ta_do0 == w_tag);
  assign w_hit1    = w_valid[1] && (i_ta_do1 == w_tag);
  assign w_hit     = w_hit0 || w_hit1;
  assign w_hit_way = !w_hit0;  // way0 wins a double hit
  assign w_victim  = !w_valid[0] ? 1'b0 : (!w_valid[1] ? 1'b1 : w_lru);

  assign o_req_ready = i_resetb && (r_state == IDLE) && !r_flush_pend && !i_flush;
  assign w_accept    = o_req_ready && i_req_valid;
  assign w_flush_clr = (r_state == IDLE) && (i_flush || r_flush_pend);

  assign w_lru_we  = ((r_state == LOOKUP) && w_hit) || (r_state == WRITE);
  assign w_lru_val = (r_state == WRITE) ? !r_victim : !w_hit_way;

  assign o_ta_cs  = 1'b1;
  assign o_ta_oe  = 1'b1;
  assign o_ta_web = (i_resetb && (r_state == WRITE)) ? (r_victim ? 2'b01 : 2'b10) : 2'b11;
  assign o_ta_a   = (r_state == IDLE) ? i_req_addr[OFS_W +: IDX_W] : w_idx;
  assign o_ta_di  = w_tag;

  assign o_rsp_valid   = r_rsp_valid;
  assign o_rsp_hit     = r_rsp_hit;
  assign o_rsp_way     = r_rsp_way;
  assign o_refill_req  = r_refill_req;
  assign o_refill_addr = {r_line, {OFS_W{1'b0}}};
  assign o_refill_way  = r_victim;

  cache_lru_valid #(
    .IDX_W (IDX_W)
  ) u_lru_valid (
    .i_clk       (i_clk),
    .i_resetb    (i_resetb),
    .i_rd_idx    (w_idx),
    .o_rd_valid  (w_valid),
    .o_rd_lru    (w_lru),
    .i_upd_idx   (w_idx),
    .i_lru_we    (w_lru_we),
    .i_lru_val   (w_lru_val),
    .i_vld_set   (r_state == WRITE),
    .i_vld_way   (r_victim),
    .i_flush_clr (w_flush_clr)
  );

  // Next-state decode.
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      IDLE:    if (w_accept) w_state_d = LOOKUP;
      LOOKUP:  w_state_d = w_hit ? IDLE : REFILL;
      REFILL:  if (i_refill_done) w_state_d = WRITE;
      WRITE:   w_state_d = IDLE;
      default: w_state_d = IDLE;
    endcase
  end

  // State, request latch, victim, flush deferral and registered responses.
  always_ff @(posedge i_clk) begin
    if (!i_resetb) begin
      r_state      <= IDLE;
      r_line       <= '0;
      r_victim     <= 1'b0;
      r_flush_pend <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_hit    <= 1'b0;
      r_rsp_way    <= 1'b0;
      r_refill_req <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_rsp_valid <= 1'b0;
      if (w_accept) begin
        r_line <= i_req_addr[ADDR_W-1:OFS_W];
      end
      if (r_state == LOOKUP) begin
        if (w_hit) begin
          r_rsp_valid <= 1'b1;
          r_rsp_hit   <= 1'b1;
          r_rsp_way   <= w_hit_way;
        end else begin
          r_victim     <= w_victim;
          r_refill_req <= 1'b1;
        end
      end
      if ((r_state == REFILL) && i_refill_done) begin
        r_refill_req <= 1'b0;
      end
      if (r_state == WRITE) begin
        r_rsp_valid <= 1'b1;
        r_rsp_hit   <= 1'b0;
        r_rsp_way   <= r_victim;
      end
      // A flush seen mid-operation is applied in the next IDLE cycle.
      if (r_state == IDLE) begin
        r_flush_pend <= 1'b0;
      end else if (i_flush) begin
        r_flush_pend <= 1'b1;
      end
    end
  end

`ifndef SYNTHESIS
  // Both ways holding the same valid tag means the array is corrupt.
  always_ff @(posedge i_clk) begin
    if (i_resetb && (r_state == LOOKUP)) begin
      assert (!(w_hit0 && w_hit1)) else $error("double hit in set %0d", w_idx);
    end
  end
`endif

`ifdef CACHE_TAG_STATS_EN
  logic [31:0] r_hit_cnt, r_miss_cnt;

  // Response counters; flush clears them.
  always_ff @(posedge i_clk) begin
    if (!i_resetb || i_flush) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else if (r_rsp_valid) begin
      if (r_rsp_hit) r_hit_cnt  <= r_hit_cnt + 32'd1;
      else           r_miss_cnt <= r_miss_cnt + 32'd1;
    end
  end

  assign o_hit_cnt  = r_hit_cnt;
  assign o_miss_cnt = r_miss_cnt;
`endif

endmodule

// File: tb/tb_cache_tag_ctrl.sv
// Directed bench for cache_tag_ctrl with a behavioural 2-way tag SRAM and a
// response scoreboard. Counter checks are built when CACHE_TAG_STATS_EN is set.
module tb_cache_tag_ctrl;
  import cache_pkg::*;

  logic        clk = 1'b0;
  logic        resetb, req_valid, flush, refill_done;
  logic [31:0] req_addr;
  logic        req_ready, rsp_valid, rsp_hit, rsp_way;
  logic        refill_req, refill_way;
  logic [31:0] refill_addr;
  logic        ta_cs, ta_oe;
  logic [1:0]  ta_web;
  logic [4:0]  ta_a;
  logic [22:0] ta_di, ta_do0, ta_do1;
`ifdef CACHE_TAG_STATS_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif

  logic [22:0] mem0 [32];
  logic [22:0] mem1 [32];
  logic        mem_init = 1'b0;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [1:0]  exp_q [$];  // {hit, way}

  always #5 clk = ~clk;

  cache_tag_ctrl u_dut (
    .i_clk         (clk),
    .i_resetb      (resetb),
    .i_req_valid   (req_valid),
    .o_req_ready   (req_ready),
    .i_req_addr    (req_addr),
    .o_rsp_valid   (rsp_valid),
    .o_rsp_hit     (rsp_hit),
    .o_rsp_way     (rsp_way),
    .o_refill_req  (refill_req),
    .o_refill_addr (refill_addr),
    .o_refill_way  (refill_way),
    .i_refill_done (refill_done),
    .i_flush       (flush),
    .o_ta_cs       (ta_cs),
    .o_ta_oe       (ta_oe),
    .o_ta_web      (ta_web),
    .o_ta_a        (ta_a),
    .o_ta_di       (ta_di),
    .i_ta_do0      (ta_do0),
    .i_ta_do1      (ta_do1)
`ifdef CACHE_TAG_STATS_EN
    ,
    .o_hit_cnt     (hit_cnt),
    .o_miss_cnt    (miss_cnt)
`endif
  );

  // Tag SRAM model: one-cycle read latency, per-way active-low write enable.
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 32; i++) begin
        mem0[i] <= '0;
        mem1[i] <= '0;
      end
      ta_do0   <= '0;
      ta_do1   <= '0;
      mem_init <= 1'b1;
    end else begin
      if (ta_cs && ta_oe) begin
        ta_do0 <= mem0[ta_a];
        ta_do1 <= mem1[ta_a];
      end
      if (ta_cs && !ta_web[0]) mem0[ta_a] <= ta_di;
      if (ta_cs && !ta_web[1]) mem1[ta_a] <= ta_di;
    end
  end

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", req_ready, 1);
  endtask

  // One lookup; serves the refill handshake if the DUT asks for it.
  task automatic lookup(input logic [31:0] addr, input logic exp_hit, input logic exp_way,
                        input bit flush_mid);
    int         cyc;
    bit         done;
    logic [1:0] e;
    wait_ready();
    exp_q.push_back({exp_hit, exp_way});
    req_valid = 1'b1;
    req_addr  = addr;
    @(negedge clk);
    req_valid = 1'b0;
    cyc  = 1;
    done = 1'b0;
    while (!done && cyc < 40) begin
      if (rsp_valid) begin
        check("sb_nonempty", (exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("rsp_hit", rsp_hit, e[1]);
          check("rsp_way", rsp_way, e[0]);
          if (e[1]) check("hit_latency", cyc, 2);
        end
        check("ready_at_rsp", req_ready, !flush_mid);
        done = 1'b1;
      end else if (refill_req) begin
        check("refill_on_miss", refill_req, !exp_hit);
        check("refill_addr", refill_addr, addr & 32'hFFFF_FFF0);
        check("refill_way", refill_way, exp_way);
        check("web_refill", ta_web, 2'b11);
        @(negedge clk);
        cyc++;
        check("refill_hold", refill_req, 1);
        refill_done = 1'b1;
        flush       = flush_mid;
        @(negedge clk);
        cyc++;
        refill_done = 1'b0;
        flush       = 1'b0;
        check("refill_drop", refill_req, 0);
        check("web_write", ta_web, exp_way ? 2'b01 : 2'b10);
        check("ta_a_write", ta_a, addr_idx(addr));
        check("ta_di_write", ta_di, addr_tag(addr));
        @(negedge clk);
        cyc++;
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    check("rsp_seen", done, 1);
    @(negedge clk);
    check("rsp_pulse", rsp_valid, 0);
  endtask

  task automatic flush_idle();
    flush = 1'b1;
    #1;
    check("ready_during_flush", req_ready, 0);
    @(negedge clk);
    flush = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    resetb      = 1'b0;
    req_valid   = 1'b0;
    req_addr    = '0;
    flush       = 1'b0;
    refill_done = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", req_ready, 0);
    check("rst_web", ta_web, 2'b11);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_refill_req", refill_req, 0);
    check("ta_cs", ta_cs, 1);
    check("ta_oe", ta_oe, 1);
    resetb = 1'b1;
    @(negedge clk);
    check("ready_after_reset", req_ready, 1);
`ifdef CACHE_TAG_STATS_EN
    check("rst_hit_cnt", hit_cnt, 0);
    check("rst_miss_cnt", miss_cnt, 0);
`endif

    // Cold miss then hit on idx 3, then LRU eviction.
    lookup(32'h0000_1230, 1'b0, 1'b0, 1'b0);
    lookup(32'h0000_1230, 1'b1, 1'b0, 1'b0);
    lookup(32'h0000_1430, 1'b0, 1'b1, 1'b0);
    lookup(32'h0000_1230, 1'b1, 1'b0, 1'b0);
    lookup(32'h0000_1630, 1'b0, 1'b1, 1'b0);
    lookup(32'h0000_1230, 1'b1, 1'b0, 1'b0);
    lookup(32'h0000_1430, 1'b0, 1'b1, 1'b0);

    // Flush in IDLE invalidates everything.
    flush_idle();
    lookup(32'h0000_1230, 1'b0, 1'b0, 1'b0);

    // Tag 0 against reset SRAM contents must still miss; extreme address.
    lookup(32'h0000_0040, 1'b0, 1'b0, 1'b0);
    lookup(32'h0000_0040, 1'b1, 1'b0, 1'b0);
    lookup(32'hFFFF_FFF0, 1'b0, 1'b0, 1'b0);
    lookup(32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0);

    // Flush during REFILL: fill completes, ready held low one extra cycle.
    lookup(32'h0000_1430, 1'b0, 1'b1, 1'b1);
    check("ready_after_pend", req_ready, 1);
    lookup(32'h0000_1430, 1'b0, 1'b0, 1'b0);
    lookup(32'h0000_1230, 1'b0, 1'b1, 1'b0);
    lookup(32'h0000_0040, 1'b0, 1'b0, 1'b0);

`ifdef CACHE_TAG_STATS_EN
    flush_idle();
    check("flush_hit_cnt", hit_cnt, 0);
    check("flush_miss_cnt", miss_cnt, 0);
    lookup(32'h0000_1230, 1'b0, 1'b0, 1'b0);
    lookup(32'h0000_1430, 1'b0, 1'b1, 1'b0);
    lookup(32'h0000_1630, 1'b0, 1'b0, 1'b0);
    lookup(32'h0000_1630, 1'b1, 1'b0, 1'b0);
    lookup(32'h0000_1430, 1'b1, 1'b1, 1'b0);
    check("stat_hit_cnt", hit_cnt, 2);
    check("stat_miss_cnt", miss_cnt, 3);
    flush_idle();
    check("stat_hit_clr", hit_cnt, 0);
    check("stat_miss_clr", miss_cnt, 0);
`endif

    // Reset while in REFILL: no tag write, back to IDLE, valids cleared.
    wait_ready();
    req_valid = 1'b1;
    req_addr  = 32'h0000_2230;
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!refill_req && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("mr_refill", refill_req, 1);
    resetb      = 1'b0;
    refill_done = 1'b1;
    @(negedge clk);
    check("mr_web", ta_web, 2'b11);
    check("mr_ready", req_ready, 0);
    check("mr_refill_req", refill_req, 0);
    check("mr_rsp", rsp_valid, 0);
    resetb      = 1'b1;
    refill_done = 1'b0;
    @(negedge clk);
    check("mr_ready_after", req_ready, 1);

    // Stray refill_done in IDLE is ignored.
    refill_done = 1'b1;
    @(negedge clk);
    refill_done = 1'b0;
    check("stray_done_refill", refill_req, 0);
    check("stray_done_rsp", rsp_valid, 0);
    check("stray_done_ready", req_ready, 1);
    lookup(32'h0000_0040, 1'b0, 1'b0, 1'b0);

    check("sb_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
